// File: rtl/spi_mem_bridge.sv
// Wishbone-classic slave mapping 32-bit word accesses onto SPI SRAM/EEPROM devices
// (mode 0, divided SCK, one chip select per device, byte-lane writes, little-endian reads).
module spi_mem_bridge #(
  parameter int       ADDR_W         = 14,
  parameter int       SPI_ADDR_BYTES = 2,
  parameter int       NUM_CS         = 2,
  parameter bit [3:0] RO_MASK        = 4'b0010,
  parameter int       CLK_DIV        = 1,
  parameter int       CS_GAP         = 2,
  parameter int       CS_W           = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  input  logic [CS_W+ADDR_W-1:0] wb_adr,
  input  logic                   wb_we,
  input  logic [31:0]            wb_dat_i,
  input  logic [3:0]             wb_sel,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_ack,
  output logic                   wb_err,
  output logic                   spi_sck,
  output logic                   spi_mosi,
  input  logic                   spi_miso,
  output logic [NUM_CS-1:0]      spi_cs_n
);

  localparam int AW = 8 * SPI_ADDR_BYTES;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWdata, StRdata, StEnd, StErr} state_t;

  state_t            r_state;
  logic [31:0]       r_gap;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdat;
  logic [31:0]       r_tx;
  logic [31:0]       r_rx;
  logic [31:0]       r_dat_o;
  logic [4:0]        r_cnt;
  logic [1:0]        r_nm1;
  logic [DW-1:0]     r_div;
  logic              r_we;
  logic              r_sck;
  logic              r_ack;
  logic              r_err;
  logic [NUM_CS-1:0] r_cs_n;

  logic [CS_W-1:0]   w_dev;
  logic [ADDR_W-1:0] w_wadr;
  logic [1:0]        w_lo;
  logic [1:0]        w_alo;
  logic [2:0]        w_n;
  logic              w_contig;
  logic              w_bad;
  logic              w_req;
  logic [31:0]       w_wdat_sh;
  logic [31:0]       w_wdat;
  logic [31:0]       w_addr_lj;
  logic [NUM_CS-1:0] w_cs_sel;

  assign w_dev     = wb_adr[CS_W+ADDR_W-1 -: CS_W];
  assign w_wadr    = wb_adr[ADDR_W-1:0];
  assign w_req     = wb_cyc & wb_stb;
  assign w_alo     = wb_we ? w_lo : 2'b00;
  assign w_cs_sel  = NUM_CS'(1) << w_dev;
  assign w_wdat_sh = wb_dat_i >> {w_lo, 3'b000};
  // Lane lo ends up in the top byte so it is shifted out first.
  assign w_wdat    = {w_wdat_sh[7:0], w_wdat_sh[15:8], w_wdat_sh[23:16], w_wdat_sh[31:24]};
  assign w_addr_lj = 32'({w_wadr, w_alo}) << (32 - AW);

  always_comb begin
    w_lo = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (wb_sel[i]) w_lo = 2'(i);
    end
    w_n = 3'(wb_sel[0]) + 3'(wb_sel[1]) + 3'(wb_sel[2]) + 3'(wb_sel[3]);
    case (wb_sel)
      4'b0101, 4'b1001, 4'b1011, 4'b1101, 4'b1010: w_contig = 1'b0;
      default:                                     w_contig = 1'b1;
    endcase
    w_bad = (32'(w_dev) >= 32'(NUM_CS)) | (wb_we & (RO_MASK[2'(w_dev)] | ~w_contig));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_gap   <= 32'(CS_GAP);
      r_addr  <= '0;
      r_wdat  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dat_o <= '0;
      r_cnt   <= '0;
      r_nm1   <= '0;
      r_div   <= '0;
      r_we    <= 1'b0;
      r_sck   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_cs_n  <= '1;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (r_gap < 32'(CS_GAP)) r_gap <= r_gap + 32'd1;
          if (w_req && (r_gap >= 32'(CS_GAP))) begin
            r_we   <= wb_we;
            r_addr <= w_addr_lj;
            r_wdat <= w_wdat;
            r_nm1  <= 2'(w_n - 3'd1);
            if (w_bad) begin
              r_state <= StErr;
              r_err   <= 1'b1;
            end else if (wb_we && (wb_sel == 4'b0000)) begin
              r_state <= StEnd;
              r_ack   <= 1'b1;
              r_gap   <= '0;
            end else begin
              r_state <= StCmd;
              r_cs_n  <= ~w_cs_sel;
              r_tx    <= {(wb_we ? 8'h02 : 8'h03), 24'h0};
              r_cnt   <= 5'd7;
              r_div   <= '0;
              r_sck   <= 1'b0;
            end
          end
        end
        StCmd, StAddr, StWdata, StRdata: begin
          if (r_div == DW'(CLK_DIV - 1)) begin
            r_div <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
              r_rx  <= {r_rx[30:0], spi_miso};
            end else begin
              r_sck <= 1'b0;
              if (r_cnt != 5'd0) begin
                r_cnt <= r_cnt - 5'd1;
                r_tx  <= {r_tx[30:0], 1'b0};
              end else begin
                case (r_state)
                  StCmd: begin
                    r_state <= StAddr;
                    r_tx    <= r_addr;
                    r_cnt   <= 5'(AW - 1);
                  end
                  StAddr: begin
                    if (r_we) begin
                      r_state <= StWdata;
                      r_tx    <= r_wdat;
                      r_cnt   <= {r_nm1, 3'b111};
                    end else begin
                      r_state <= StRdata;
                      r_tx    <= '0;
                      r_cnt   <= 5'd31;
                    end
                  end
                  default: begin
                    r_state <= StEnd;
                    r_cs_n  <= '1;
                    r_tx    <= '0;
                    r_gap   <= '0;
                    r_ack   <= w_req;
                    // First received byte sits in r_rx[31:24] and belongs in lane 0.
                    if (!r_we) r_dat_o <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                  end
                endcase
              end
            end
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        StEnd, StErr: begin
          if (r_gap < 32'(CS_GAP)) r_gap <= r_gap + 32'd1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign wb_dat_o = r_dat_o;
  assign wb_ack   = r_ack;
  assign wb_err   = r_err;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_tx[31];
  assign spi_cs_n = r_cs_n;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge: a fast 2-byte-address instance with an SPI memory model
// on device 0, and a divided 3-byte-address instance with MISO tied high.
module tb_spi_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cyc0, cyc1, stb, we;
  logic [15:0] adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1, err0, err1;
  logic        sck0, sck1, mosi0, mosi1;
  logic        miso0 = 1'b0;
  logic        miso1;
  logic [1:0]  cs0;
  logic [2:0]  cs1;

  int checks = 0;
  int errors = 0;

  assign miso1 = 1'b1;

  spi_mem_bridge #(
    .ADDR_W(14), .SPI_ADDR_BYTES(2), .NUM_CS(2), .RO_MASK(4'b0010), .CLK_DIV(1), .CS_GAP(2)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc0), .wb_stb(stb), .wb_adr(adr[14:0]), .wb_we(we),
    .wb_dat_i(dat_i), .wb_sel(sel), .wb_dat_o(dat0), .wb_ack(ack0), .wb_err(err0),
    .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso0), .spi_cs_n(cs0)
  );

  spi_mem_bridge #(
    .ADDR_W(14), .SPI_ADDR_BYTES(3), .NUM_CS(3), .RO_MASK(4'b0010), .CLK_DIV(3), .CS_GAP(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc1), .wb_stb(stb), .wb_adr(adr), .wb_we(we),
    .wb_dat_i(dat_i), .wb_sel(sel), .wb_dat_o(dat1), .wb_ack(ack1), .wb_err(err1),
    .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1), .spi_cs_n(cs1)
  );

  // SPI memory model behind device 0 of u_dut0 (02 write / 03 read, 16-bit address)
  logic [7:0]  mem [0:255];
  logic [63:0] m_frame = '0;
  int          m_bits = 0;
  int          m_j;
  logic [7:0]  m_cmd = '0;
  logic [7:0]  m_adr = '0;
  logic [7:0]  m_byte;

  always @(negedge cs0[0]) begin
    m_bits  = 0;
    m_frame = '0;
  end

  always @(posedge sck0) begin
    if (!cs0[0]) begin
      m_frame = {m_frame[62:0], mosi0};
      m_bits++;
      if (m_bits == 8) m_cmd = m_frame[7:0];
      if (m_bits == 24) m_adr = m_frame[7:0];
      if (m_bits > 24 && (m_bits % 8) == 0 && m_cmd == 8'h02) begin
        mem[m_adr] = m_frame[7:0];
        m_adr++;
      end
    end
  end

  always @(negedge sck0) begin
    if (!cs0[0] && m_bits >= 24 && m_cmd == 8'h03) begin
      m_j    = m_bits - 24;
      m_byte = mem[m_adr + 8'(m_j / 8)];
      miso0  = m_byte[7 - (m_j % 8)];
    end
  end

  // MOSI capture and SCK phase lengths on u_dut1 device 0
  logic [63:0] m1_frame = '0;
  int          m1_bits = 0;
  int          run1 = 0, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
  logic        in_frame1 = 1'b0, prev_sck1 = 1'b0;

  always @(negedge cs1[0]) begin
    m1_bits  = 0;
    m1_frame = '0;
  end

  always @(posedge sck1) begin
    if (!cs1[0]) begin
      m1_frame = {m1_frame[62:0], mosi1};
      m1_bits++;
    end
  end

  always @(negedge clk) begin
    if (cs1 != 3'b111) begin
      if (in_frame1 && sck1 == prev_sck1) begin
        run1++;
      end else begin
        if (in_frame1) begin
          if (prev_sck1) begin
            if (run1 < hi_min) hi_min = run1;
            if (run1 > hi_max) hi_max = run1;
          end else begin
            if (run1 < lo_min) lo_min = run1;
            if (run1 > lo_max) lo_max = run1;
          end
        end
        run1 = 1;
      end
      in_frame1 = 1'b1;
      prev_sck1 = sck1;
    end else begin
      in_frame1 = 1'b0;
    end
  end

  // Length of the most recent all-high stretch of cs0 that ended in a frame start
  int hrun0 = 0, last_gap0 = 0;
  always @(negedge clk) begin
    if (cs0 == 2'b11) begin
      hrun0++;
    end else begin
      if (hrun0 > 0) last_gap0 = hrun0;
      hrun0 = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wb_go(input bit d1, input bit w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cyc0  = !d1;
    cyc1  = d1;
    stb   = 1'b1;
    we    = w;
    adr   = a;
    dat_i = d;
    sel   = s;
  endtask

  task automatic wb_idle();
    cyc0 = 1'b0;
    cyc1 = 1'b0;
    stb  = 1'b0;
    we   = 1'b0;
  endtask

  task automatic wait_resp(input bit d1, input int limit, output int lat, output bit got_ack,
                           output bit got_err, output bit cs_low);
    lat     = 0;
    got_ack = 1'b0;
    got_err = 1'b0;
    cs_low  = 1'b0;
    while (lat < limit && !got_ack && !got_err) begin
      @(posedge clk);
      #1;
      lat++;
      got_ack = d1 ? ack1 : ack0;
      got_err = d1 ? err1 : err0;
      if (d1 ? (cs1 != 3'b111) : (cs0 != 2'b11)) cs_low = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit ga, ge, cl, seen;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'h14] = 8'h55; mem[8'h15] = 8'h66; mem[8'h16] = 8'h77; mem[8'h17] = 8'h88;

    rst_n = 1'b0;
    wb_idle();
    adr = '0; dat_i = '0; sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs0", cs0, 2'b11);
    check("rst_cs1", cs1, 3'b111);
    check("rst_sck", sck0, 1'b0);
    check("rst_mosi", mosi0, 1'b0);
    check("rst_ack_err", {ack0, err0}, 2'b00);
    check("rst_dat", dat0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-word read, device 0, byte address 0x10
    wb_go(1'b0, 1'b0, 16'h0004, 32'h0, 4'b0000);
    wait_resp(1'b0, 300, lat, ga, ge, cl);
    wb_idle();
    check("rd_ack", {ga, ge}, 2'b10);
    check("rd_lat", lat, 113);
    check("rd_data", dat0, 32'h44332211);
    check("rd_bits", m_bits, 56);
    check("rd_hdr", m_frame[55:32], 24'h030010);
    check("rd_cs_end", cs0, 2'b11);
    @(posedge clk);
    #1;
    check("rd_ack_single", ack0, 1'b0);

    // Lane write, sel 1100
    repeat (3) @(posedge clk);
    #1;
    wb_go(1'b0, 1'b1, 16'h0004, 32'hAABBCCDD, 4'b1100);
    wait_resp(1'b0, 300, lat, ga, ge, cl);
    wb_idle();
    check("wr_ack", {ga, ge}, 2'b10);
    check("wr_lat", lat, 81);
    check("wr_bits", m_bits, 40);
    check("wr_frame", m_frame[39:0], 40'h020012BBAA);
    check("wr_mem", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'h1122BBAA);
    check("wr_dat_hold", dat0, 32'h44332211);

    // Empty write
    repeat (3) @(posedge clk);
    #1;
    wb_go(1'b0, 1'b1, 16'h0005, 32'h12345678, 4'b0000);
    wait_resp(1'b0, 20, lat, ga, ge, cl);
    wb_idle();
    check("empty_ack", {ga, ge, cl}, 3'b100);
    check("empty_lat", lat, 1);
    check("empty_mem", {mem[8'h14], mem[8'h15]}, 16'h5566);

    // Write to read-only device 1
    repeat (3) @(posedge clk);
    #1;
    wb_go(1'b0, 1'b1, 16'h4004, 32'h12345678, 4'b1111);
    wait_resp(1'b0, 20, lat, ga, ge, cl);
    wb_idle();
    check("ro_err", {ga, ge, cl}, 3'b010);
    check("ro_lat", lat, 1);
    @(posedge clk);
    #1;
    check("ro_err_single", err0, 1'b0);

    // Non-contiguous byte lanes
    repeat (2) @(posedge clk);
    #1;
    wb_go(1'b0, 1'b1, 16'h0004, 32'h12345678, 4'b0101);
    wait_resp(1'b0, 20, lat, ga, ge, cl);
    wb_idle();
    check("sel_err", {ga, ge, cl}, 3'b010);
    check("sel_lat", lat, 1);

    // Out-of-range device index on the 3-CS instance
    repeat (2) @(posedge clk);
    #1;
    wb_go(1'b1, 1'b0, 16'hC004, 32'h0, 4'b1111);
    wait_resp(1'b1, 20, lat, ga, ge, cl);
    wb_idle();
    check("dev3_err", {ga, ge, cl}, 3'b010);
    check("dev3_lat", lat, 1);

    // Divided clock, 3-byte address
    repeat (3) @(posedge clk);
    #1;
    wb_go(1'b1, 1'b0, 16'h0123, 32'h0, 4'b0000);
    wait_resp(1'b1, 600, lat, ga, ge, cl);
    wb_idle();
    check("div_ack", {ga, ge}, 2'b10);
    check("div_lat", lat, 385);
    check("div_data", dat1, 32'hFFFFFFFF);
    check("div_bits", m1_bits, 64);
    check("div_hdr", m1_frame[63:32], 32'h0300048C);
    check("div_hi", {8'(hi_min), 8'(hi_max)}, 16'h0303);
    check("div_lo", {8'(lo_min), 8'(lo_max)}, 16'h0303);

    // Back-to-back reads with cyc held
    repeat (3) @(posedge clk);
    #1;
    wb_go(1'b0, 1'b0, 16'h0004, 32'h0, 4'b0000);
    wait_resp(1'b0, 300, lat, ga, ge, cl);
    check("b2b_ack1", {ga, ge}, 2'b10);
    check("b2b_data1", dat0, 32'hAABB2211);
    wb_go(1'b0, 1'b0, 16'h0005, 32'h0, 4'b0000);
    wait_resp(1'b0, 300, lat, ga, ge, cl);
    wb_idle();
    check("b2b_ack2", {ga, ge}, 2'b10);
    check("b2b_data2", dat0, 32'h88776655);
    check("b2b_gap", last_gap0 >= 2, 1'b1);

    // wb_cyc dropped mid-read
    repeat (3) @(posedge clk);
    #1;
    wb_go(1'b0, 1'b0, 16'h0004, 32'h0, 4'b0000);
    repeat (30) @(posedge clk);
    #1;
    wb_idle();
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      if (ack0 || err0) seen = 1'b1;
    end
    check("abort_no_ack", seen, 1'b0);
    check("abort_bits", m_bits, 56);
    check("abort_cs", cs0, 2'b11);

    // Async reset in the address phase
    wb_go(1'b0, 1'b0, 16'h0004, 32'h0, 4'b0000);
    repeat (20) @(posedge clk);
    #1;
    check("pre_rst_cs", cs0, 2'b10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs", cs0, 2'b11);
    check("rst_mid_sck", sck0, 1'b0);
    wb_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 130; i++) begin
      @(posedge clk);
      #1;
      if (ack0 || err0) seen = 1'b1;
    end
    check("rst_no_ack", seen, 1'b0);
    check("rst_dat_cleared", dat0, 32'h0);
    wb_go(1'b0, 1'b0, 16'h0004, 32'h0, 4'b0000);
    wait_resp(1'b0, 300, lat, ga, ge, cl);
    wb_idle();
    check("post_rst_ack", {ga, ge}, 2'b10);
    check("post_rst_lat", lat, 113);
    check("post_rst_data", dat0, 32'hAABB2211);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
